// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: multicycle MIPS main control FSM with memory-ready stretch and retired-instruction counter.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to lock into TRAP on an illegal opcode until reset.
module mips_multicycle_controller #(
    parameter int USE_MEM_READY = 1,
    parameter int COUNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [1:0]         AluOP,
    output logic [1:0]         PCSrc,
    output logic               PCWrite,
    output logic               Branch,
    output logic               instr_done,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP     = 4'd12;
`endif

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_rdy;
    logic       w_legal;

    assign w_rdy   = (USE_MEM_READY == 0) || mem_ready;
    assign w_legal = opcode inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (instr_done)
                instr_count <= instr_count + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    6'b100011, 6'b101011: w_next = S_MEMADR;
                    6'b000000:            w_next = S_EXECUTE;
                    6'b000100:            w_next = S_BRANCH;
                    6'b001000:            w_next = S_ADDIEXEC;
                    6'b000010:            w_next = S_JUMP;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                    default:              w_next = S_TRAP;
`else
                    default:              w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (opcode == 6'b101011) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = w_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next = w_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ADDIEXEC: w_next = S_ADDIWB;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     w_next = S_TRAP;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // Everything is held low during reset so an abandoned instruction never writes.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        AluSrcA    = 1'b0;
        AluSrcB    = 2'b00;
        AluOP      = 2'b00;
        PCSrc      = 2'b00;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    AluSrcB = 2'b01;
                    IRWrite = w_rdy;
                    PCWrite = w_rdy;
                end
                S_DECODE: begin
                    AluSrcB = 2'b11;
                    illegal = !w_legal;
                end
                S_MEMADR, S_ADDIEXEC: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                end
                S_MEMREAD:  IorD = 1'b1;
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    IorD       = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = w_rdy;
                end
                S_EXECUTE: begin
                    AluSrcA = 1'b1;
                    AluOP   = 2'b10;
                end
                S_ALUWB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    AluSrcA    = 1'b1;
                    AluOP      = 2'b01;
                    PCSrc      = 2'b01;
                    Branch     = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCSrc      = 2'b10;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                S_TRAP:     illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed checks of the multicycle MIPS control FSM.
// Control outputs are packed into one vector and compared against hand-built per-state constants.
module tb_mips_multicycle_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, AluSrcA;
    logic [1:0]  AluSrcB, AluOP, PCSrc;
    logic        PCWrite, Branch, instr_done, illegal;
    logic [31:0] instr_count;
    logic [16:0] ctl;
    int          total = 0;
    int          bad = 0;

    mips_multicycle_controller #(.USE_MEM_READY(1), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .AluOP(AluOP), .PCSrc(PCSrc), .PCWrite(PCWrite), .Branch(Branch),
        .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign ctl = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, AluSrcA,
                  AluSrcB, AluOP, PCSrc, PCWrite, Branch, instr_done, illegal};

    // Field order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite AluSrcA AluSrcB AluOP PCSrc PCWrite Branch instr_done illegal
    localparam logic [16:0] E_ZERO    = 17'd0;
    localparam logic [16:0] E_FETCH   = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_FWAIT   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_DECODE  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_DECILL  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [16:0] E_MEMADR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_MEMREAD = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_MEMWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_MWWAIT  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_MWDONE  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_EXECUTE = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_ALUWB   = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_BRANCH  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [16:0] E_ADDIEX  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_ADDIWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_JUMP    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [16:0] E_TRAP    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied at the falling edge; outputs are checked 1 time unit later, then one cycle elapses.
    task automatic step(input string tag, input logic [16:0] e);
        #1;
        chk(tag, 32'(ctl), 32'(e));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b100011;
        @(negedge clk);
        @(negedge clk);
        #1 chk("rst_count", instr_count, 32'd0);
        step("rst_ctl", E_ZERO);
        reset = 1'b0;
        step("lw_fetch", E_FETCH);
        step("lw_decode", E_DECODE);
        step("lw_memadr", E_MEMADR);
        step("lw_memread", E_MEMREAD);
        step("lw_memwb", E_MEMWB);
        #1 chk("lw_count", instr_count, 32'd1);
        opcode = 6'b000000;
        step("r_fetch", E_FETCH);
        step("r_decode", E_DECODE);
        step("r_execute", E_EXECUTE);
        step("r_aluwb", E_ALUWB);
        opcode = 6'b000100;
        step("beq_fetch", E_FETCH);
        step("beq_decode", E_DECODE);
        step("beq_branch", E_BRANCH);
        #1 chk("beq_count", instr_count, 32'd3);
        opcode = 6'b001000;
        step("addi_fetch", E_FETCH);
        step("addi_decode", E_DECODE);
        step("addi_exec", E_ADDIEX);
        step("addi_wb", E_ADDIWB);
        opcode = 6'b000010;
        step("j_fetch", E_FETCH);
        step("j_decode", E_DECODE);
        step("j_jump", E_JUMP);
        #1 chk("j_count", instr_count, 32'd5);
        opcode = 6'b101011;
        mem_ready = 1'b0;
        step("sw_fetch_wait0", E_FWAIT);
        step("sw_fetch_wait1", E_FWAIT);
        mem_ready = 1'b1;
        step("sw_fetch", E_FETCH);
        step("sw_decode", E_DECODE);
        step("sw_memadr", E_MEMADR);
        mem_ready = 1'b0;
        step("sw_mw_wait0", E_MWWAIT);
        step("sw_mw_wait1", E_MWWAIT);
        step("sw_mw_wait2", E_MWWAIT);
        mem_ready = 1'b1;
        step("sw_mw_done", E_MWDONE);
        #1 chk("sw_count", instr_count, 32'd6);
        opcode = 6'b100011;
        step("lw2_fetch", E_FETCH);
        step("lw2_decode", E_DECODE);
        step("lw2_memadr", E_MEMADR);
        mem_ready = 1'b0;
        step("lw2_memread_wait", E_MEMREAD);
        mem_ready = 1'b1;
        step("lw2_memread", E_MEMREAD);
        step("lw2_memwb", E_MEMWB);
        #1 chk("lw2_count", instr_count, 32'd7);
        opcode = 6'b111111;
        step("ill_fetch", E_FETCH);
        step("ill_decode", E_DECILL);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        step("ill_trap0", E_TRAP);
        step("ill_trap1", E_TRAP);
        step("ill_trap2", E_TRAP);
        #1 chk("ill_count", instr_count, 32'd7);
        reset = 1'b1;
        step("ill_reset", E_ZERO);
        reset = 1'b0;
        #1 chk("ill_count_rst", instr_count, 32'd0);
`else
        #1 chk("ill_count", instr_count, 32'd7);
`endif
        opcode = 6'b100011;
        step("abort_fetch", E_FETCH);
        step("abort_decode", E_DECODE);
        step("abort_memadr", E_MEMADR);
        mem_ready = 1'b0;
        step("abort_memread", E_MEMREAD);
        reset = 1'b1;
        step("abort_reset", E_ZERO);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1 chk("abort_count", instr_count, 32'd0);
        step("abort_refetch", E_FETCH);
        step("abort_redecode", E_DECODE);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Main control FSM for the multicycle MIPS core: sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath enables and mux selects, and produces the 2-bit AluOP consumed directly by the ALU decoder stage. A memory-ready handshake stretches the memory states, and a retired-instruction counter is provided for bring-up.

Parameters:
USE_MEM_READY, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1
COUNT_W, 32, width of instr_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
opcode  input  6  instr[31:26] from the instruction register
mem_ready  input  1  memory access completes this cycle
IorD  output  1  memory address select (0 = PC, 1 = ALUOut)
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register load enable
RegDst  output  1  write register select (0 = rt, 1 = rd)
MemtoReg  output  1  writeback select (0 = ALUOut, 1 = data)
RegWrite  output  1  register file write enable (WE3)
AluSrcA  output  1  0 = PC, 1 = register A
AluSrcB  output  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2
AluOP  output  2  to ALU decoder: 00 = add, 01 = subtract, 10 = use funct
PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
PCWrite  output  1  unconditional PC enable
Branch  output  1  conditional PC enable (datapath ANDs with Zero)
instr_done  output  1  one-cycle pulse in the last state of each instruction
illegal  output  1  unsupported opcode detected (see Optional Feature)
instr_count  output  COUNT_W  retired-instruction count

Behaviour:
- Moore FSM: all control outputs decode from state only, except FETCH and memory-state gating by mem_ready. Unlisted outputs are 0.
- Reset: state <= FETCH, instr_count <= 0, illegal <= 0. While reset=1, every control output is forced to 0. Reset mid-instruction abandons it with no register or memory write.
- FETCH: AluSrcA=0, AluSrcB=01, AluOP=00, PCSrc=00, IorD=0. IRWrite and PCWrite are high only when mem_ready=1, so the PC increments exactly once. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: AluSrcA=0, AluSrcB=11, AluOP=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEXEC
  - 000010 (j) -> JUMP
  - anything else -> illegal handling
- MEMADR: AluSrcA=1, AluSrcB=10, AluOP=00. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: IorD=1. Hold while mem_ready=0, then go to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Then FETCH.
- MEMWRITE: IorD=1, MemWrite=1, held until mem_ready=1. In that cycle instr_done=1, then FETCH.
- EXECUTE: AluSrcA=1, AluSrcB=00, AluOP=10. Then ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Then FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOP=01, PCSrc=01, Branch=1, instr_done=1. Then FETCH.
- ADDIEXEC: AluSrcA=1, AluSrcB=10, AluOP=00. Then ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Then FETCH.
- JUMP: PCSrc=10, PCWrite=1, instr_done=1. Then FETCH.
- Cycle counts with mem_ready constantly 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- instr_count increments by 1 on each clock edge where instr_done=1, and wraps modulo 2^COUNT_W.
- Illegal opcode, macro off: go DECODE -> FETCH, pulse illegal for one cycle (in DECODE), no writes, no instr_done.
- Unreachable state encodings return to FETCH on the next clock.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE moves to TRAP. TRAP drives all control outputs 0, keeps illegal=1, and holds until reset; instr_count is frozen.
- Undefined: TRAP does not exist; illegal opcodes follow the one-cycle-pulse behaviour above.

Test Plan:
- Reset held 2 cycles, mem_ready=1 -> all controls 0, instr_count=0; first cycle after release shows FETCH with IRWrite=1, PCWrite=1, AluSrcB=01.
- opcode=100011 (lw), mem_ready=1 -> 5-cycle sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with MemtoReg=1 in cycle 5; instr_count=1.
- opcode=000000 (R-type) -> AluOP=10 in cycle 3 (EXECUTE); ALUWB has RegDst=1, RegWrite=1; then opcode=000100 (beq) gives AluOP=01, Branch=1, PCSrc=01 in cycle 3.
- opcode=101011 (sw) with mem_ready low for 3 cycles in MEMWRITE -> MemWrite held 4 cycles, instr_done only on the mem_ready=1 cycle; mem_ready low in FETCH -> PCWrite stays 0 until it rises.
- opcode=111111 -> macro off: illegal pulses for 1 cycle, back to FETCH, no RegWrite/MemWrite; macro on: illegal stays 1, all controls 0, until reset returns to FETCH.
- Reset asserted during MEMREAD of lw -> next cycle in FETCH, no RegWrite ever asserted, instr_count=0.
